uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SYS_CLK_FRE, 100_000_000, system clock frequency in Hz.
REQ-002 BPS, 115200, baud rate; BPS_CNT = SYS_CLK_FRE/BPS (integer divide) SHALL be the cycles per bit.
REQ-003 DATA_BITS, 8, data bits per frame, legal range 5..8.
REQ-004 PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 STOP_BITS, 1, stop bits per frame, legal values 1 or 2.
REQ-006 FIFO_DEPTH, 4, transmit buffer depth, power of two, >= 2.
REQ-007 sys_clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-009 s_data  in  DATA_BITS  byte/word to transmit.
REQ-010 s_valid  in  1  s_data valid.
REQ-011 s_ready  out  1  buffer can accept; equals FIFO not full.
REQ-012 uart_txd  out  1  serial line, idle high, registered.
REQ-013 busy  out  1  high while a frame is on the line or the FIFO is non-empty.
REQ-014 fifo_level  out  clog2(FIFO_DEPTH)+1  words currently buffered.
REQ-015 tx_done  out  1  one-cycle pulse at end of each frame's last stop bit.

Function
REQ-016 A word SHALL be written into the FIFO on every edge where s_valid && s_ready; s_valid with s_ready low SHALL be ignored (no drop, no overwrite).
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY==0.
REQ-018 IDLE: uart_txd=1; if FIFO non-empty, pop head into shift register and enter START.
REQ-019 Word accepted into empty FIFO at edge k while IDLE: pop at edge k+1, uart_txd low from edge k+1.
REQ-020 START drives 0, DATA drives bits LSB first, PARITY drives XOR of data bits (even) or its inverse (odd), STOP drives 1; each bit held exactly BPS_CNT cycles.
REQ-021 Frame length SHALL be 1+DATA_BITS+(PARITY!=0)+STOP_BITS bit periods.
REQ-022 At end of last stop-bit period: tx_done pulses one cycle; if FIFO non-empty, next START begins the very next cycle (no idle gap), else IDLE.
REQ-023 Push and pop on the same edge SHALL both take effect; fifo_level unchanged.
REQ-024 Push while full cannot occur (s_ready low); pop while empty SHALL not occur; pointers wrap modulo FIFO_DEPTH.
REQ-025 Bit counter and clock-divider counter SHALL be wide enough for DATA_BITS+4 and BPS_CNT-1 respectively, no overflow.
REQ-026 s_data changing after acceptance SHALL not affect the frame in flight or buffered words.

Reset
REQ-027 Asserting sys_rst_n low SHALL immediately force uart_txd=1, tx_done=0, FSM=IDLE, counters=0, FIFO empty (fifo_level=0, s_ready=1, busy=0), including mid-frame.
REQ-028 After deassertion, no frame SHALL start until a new word is accepted.

Structure
REQ-029 Parity-mode encodings and FSM state encodings SHALL live in shared package uart_pkg, reused by the future receiver.
REQ-030 The buffer SHALL be a sub-module uart_tx_fifo (synchronous FIFO, parameters width/depth, push/pop/full/empty/level).

Verification (SYS_CLK_FRE=1_000_000, BPS=100_000 -> BPS_CNT=10)
REQ-031 Defaults 8N1, send 0x55 -> line 0,1,0,1,0,1,0,1,0,1 each 10 cycles, tx_done at cycle 100 after start edge.
REQ-032 DATA_BITS=7, PARITY=1, STOP_BITS=2, send 0x03 -> 0,1,1,0,0,0,0,0,parity 0,1,1 (11 bits, 110 cycles).
REQ-033 PARITY=2, send 0x00 -> parity bit 1; send 0xFF -> parity bit 1.
REQ-034 Burst 5 words 0x11..0x15 with FIFO_DEPTH=4 during IDLE -> s_ready low after 4 buffered (one pops first), all 5 frames back-to-back, no gap, correct order, fifo_level returns 0.
REQ-035 Assert sys_rst_n low at DATA bit 3 of 0xA5 -> uart_txd=1 same cycle, fifo_level=0; post-reset line stays high until new write.
REQ-036 Push on same edge as IDLE pop with level 1 -> level stays 1, both words transmitted in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM states and the
// parity helper. The future receiver imports the same encodings.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam int unsigned MAX_DATA_BITS = 8;

   // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
   function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                       input parity_e                  mode);
      return (^data) ^ (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO buffering words for the UART transmitter.
// o_data always presents the head word; a pop consumes it on the next edge.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_do_push;
   logic             w_do_pop;

   // Guard both sides so a stray push-when-full or pop-when-empty is a no-op.
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   assign o_full  = (r_level == (AW+1)'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_data  = r_mem[r_rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage array; contents need no reset because occupancy gates every read.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small input FIFO.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | line high, waiting for a buffered word
//   ST_START  | start bit (0) for one bit period
//   ST_DATA   | data bits, LSB first, one bit period each
//   ST_PARITY | parity bit (only when parity is enabled)
//   ST_STOP   | stop bit(s) (1); last one ends the frame
//
// The head word is popped in the same edge that enters ST_START, so a word
// pushed into an idle, empty buffer goes on the line one cycle later, and
// back-to-back frames follow each other with no idle cycle.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int SYS_CLK_FRE = 100_000_000,
   parameter int BPS         = 115200,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst_n,
   input  logic [DATA_BITS-1:0]          s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic                          uart_txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          tx_done
);

   localparam int      BPS_CNT    = SYS_CLK_FRE / BPS;
   localparam int      CNT_W      = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
   localparam int      BIT_W      = $clog2(DATA_BITS + 5);
   localparam parity_e PAR_MODE   = parity_e'(2'(PARITY));
   localparam bit      HAS_PARITY = (PAR_MODE != PAR_NONE);

   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(BPS_CNT - 1);
   localparam logic [BIT_W-1:0] DATA_LOAD = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LOAD = BIT_W'(STOP_BITS - 1);

   tx_state_e              r_state;
   logic [CNT_W-1:0]       r_clk_cnt;
   logic [BIT_W-1:0]       r_bit_cnt;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_parity;
   logic                   r_txd;
   logic                   r_tx_done;

   logic [DATA_BITS-1:0]   w_fifo_data;
   logic                   w_fifo_full;
   logic                   w_fifo_empty;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_bit_end;
   logic                   w_frame_end;

   assign w_push      = s_valid && !w_fifo_full;
   assign w_bit_end   = (r_clk_cnt == '0);
   assign w_frame_end = (r_state == ST_STOP) && w_bit_end && (r_bit_cnt == '0);
   assign w_pop       = !w_fifo_empty && ((r_state == ST_IDLE) || w_frame_end);

   assign s_ready  = !w_fifo_full;
   assign busy     = (r_state != ST_IDLE) || !w_fifo_empty;
   assign uart_txd = r_txd;
   assign tx_done  = r_tx_done;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (sys_clk),
      .i_rst_n (sys_rst_n),
      .i_push  (w_push),
      .i_data  (s_data),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_level (fifo_level)
   );

   // Frame sequencer: bit timer counts down from BPS_CNT-1 and each bit ends at zero.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state   <= ST_IDLE;
         r_clk_cnt <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_txd     <= 1'b1;
         r_tx_done <= 1'b0;
      end else begin
         r_tx_done <= w_frame_end;
         if (w_pop) begin
            r_shift   <= w_fifo_data;
            r_parity  <= parity_bit(MAX_DATA_BITS'(w_fifo_data), PAR_MODE);
            r_txd     <= 1'b0;
            r_clk_cnt <= CNT_LOAD;
            r_state   <= ST_START;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_txd <= 1'b1;
               end
               ST_START: begin
                  if (!w_bit_end) begin
                     r_clk_cnt <= r_clk_cnt - 1'b1;
                  end else begin
                     r_clk_cnt <= CNT_LOAD;
                     r_txd     <= r_shift[0];
                     r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                     r_bit_cnt <= DATA_LOAD;
                     r_state   <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (!w_bit_end) begin
                     r_clk_cnt <= r_clk_cnt - 1'b1;
                  end else begin
                     r_clk_cnt <= CNT_LOAD;
                     if (r_bit_cnt != '0) begin
                        r_txd     <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                     end else if (HAS_PARITY) begin
                        r_txd   <= r_parity;
                        r_state <= ST_PARITY;
                     end else begin
                        r_txd     <= 1'b1;
                        r_bit_cnt <= STOP_LOAD;
                        r_state   <= ST_STOP;
                     end
                  end
               end
               ST_PARITY: begin
                  if (!w_bit_end) begin
                     r_clk_cnt <= r_clk_cnt - 1'b1;
                  end else begin
                     r_clk_cnt <= CNT_LOAD;
                     r_txd     <= 1'b1;
                     r_bit_cnt <= STOP_LOAD;
                     r_state   <= ST_STOP;
                  end
               end
               ST_STOP: begin
                  if (!w_bit_end) begin
                     r_clk_cnt <= r_clk_cnt - 1'b1;
                  end else if (r_bit_cnt != '0) begin
                     r_clk_cnt <= CNT_LOAD;
                     r_bit_cnt <= r_bit_cnt - 1'b1;
                  end else begin
                     r_txd   <= 1'b1;
                     r_state <= ST_IDLE;
                  end
               end
               default: begin
                  r_txd   <= 1'b1;
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three configurations (8N1, 7E2, 8O1) at BPS_CNT=10,
// directed frame checks against fixed bit patterns plus a cycle-level
// waveform model (queue of expected line levels) under random traffic.
module tb_uart_tx_cfg;

   localparam int BPS_CNT = 10;
   localparam int DEPTH   = 4;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b1;
   logic [2:0] s_valid   = '0;
   logic [7:0] s_data [3];

   logic       txd_a, txd_b, txd_c;
   logic       rdy_a, rdy_b, rdy_c;
   logic       bsy_a, bsy_b, bsy_c;
   logic       don_a, don_b, don_c;
   logic [2:0] lvl_a, lvl_b, lvl_c;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // reference model state
   bit          lineq [3][$];
   int unsigned wordq [3][$];
   bit          exp_done [3];
   bit          acc [3];
   int          nbits [3] = '{8, 7, 8};
   int          pmode [3] = '{0, 1, 2};
   int          nstop [3] = '{1, 2, 1};

   always #5 sys_clk = ~sys_clk;

   uart_tx_cfg #(.SYS_CLK_FRE(1_000_000), .BPS(100_000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .s_data(s_data[0]), .s_valid(s_valid[0]),
      .s_ready(rdy_a), .uart_txd(txd_a), .busy(bsy_a), .fifo_level(lvl_a), .tx_done(don_a));

   uart_tx_cfg #(.SYS_CLK_FRE(1_000_000), .BPS(100_000), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_b (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .s_data(s_data[1][6:0]), .s_valid(s_valid[1]),
      .s_ready(rdy_b), .uart_txd(txd_b), .busy(bsy_b), .fifo_level(lvl_b), .tx_done(don_b));

   uart_tx_cfg #(.SYS_CLK_FRE(1_000_000), .BPS(100_000), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_c (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .s_data(s_data[2]), .s_valid(s_valid[2]),
      .s_ready(rdy_c), .uart_txd(txd_c), .busy(bsy_c), .fifo_level(lvl_c), .tx_done(don_c));

   function automatic logic [31:0] get_txd(int i);
      return (i == 0) ? 32'(txd_a) : (i == 1) ? 32'(txd_b) : 32'(txd_c);
   endfunction
   function automatic logic [31:0] get_rdy(int i);
      return (i == 0) ? 32'(rdy_a) : (i == 1) ? 32'(rdy_b) : 32'(rdy_c);
   endfunction
   function automatic logic [31:0] get_bsy(int i);
      return (i == 0) ? 32'(bsy_a) : (i == 1) ? 32'(bsy_b) : 32'(bsy_c);
   endfunction
   function automatic logic [31:0] get_don(int i);
      return (i == 0) ? 32'(don_a) : (i == 1) ? 32'(don_b) : 32'(don_c);
   endfunction
   function automatic logic [31:0] get_lvl(int i);
      return (i == 0) ? 32'(lvl_a) : (i == 1) ? 32'(lvl_b) : 32'(lvl_c);
   endfunction

   task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s[%0d] observed %0h expected %0h", tag, i, obs, exp);
      end
   endtask

   // Expected line waveform of one whole frame, one entry per clock cycle.
   function automatic void build_frame(int i, int unsigned w);
      int ones = 0;
      bit b;
      for (int c = 0; c < BPS_CNT; c++) lineq[i].push_back(1'b0);
      for (int d = 0; d < nbits[i]; d++) begin
         b = w[d];
         ones += int'(b);
         for (int c = 0; c < BPS_CNT; c++) lineq[i].push_back(b);
      end
      if (pmode[i] != 0) begin
         b = ((ones % 2) == 1) ^ (pmode[i] == 2);
         for (int c = 0; c < BPS_CNT; c++) lineq[i].push_back(b);
      end
      for (int c = 0; c < BPS_CNT * nstop[i]; c++) lineq[i].push_back(1'b1);
   endfunction

   // Model advances once per clock edge; frames are cut into per-cycle levels.
   always @(posedge sys_clk or negedge sys_rst_n) begin
      for (int i = 0; i < 3; i++) begin
         if (!sys_rst_n) begin
            lineq[i].delete();
            wordq[i].delete();
            exp_done[i] = 1'b0;
            acc[i]      = 1'b0;
         end else begin
            bit push;
            exp_done[i] = 1'b0;
            acc[i]      = 1'b0;
            push = s_valid[i] && (wordq[i].size() < DEPTH);
            if (lineq[i].size() > 0) begin
               void'(lineq[i].pop_front());
               if (lineq[i].size() == 0) exp_done[i] = 1'b1;
            end
            if (lineq[i].size() == 0 && wordq[i].size() > 0) build_frame(i, wordq[i].pop_front());
            if (push) begin
               wordq[i].push_back(int'(s_data[i]) & ((1 << nbits[i]) - 1));
               acc[i] = 1'b1;
            end
         end
      end
   end

   // Every cycle, every instance must match the model.
   always @(negedge sys_clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            check("txd",   i, get_txd(i), (lineq[i].size() > 0) ? 32'(lineq[i][0]) : 32'd1);
            check("done",  i, get_don(i), 32'(exp_done[i]));
            check("level", i, get_lvl(i), 32'(wordq[i].size()));
            check("ready", i, get_rdy(i), 32'(wordq[i].size() < DEPTH));
            check("busy",  i, get_bsy(i), 32'((lineq[i].size() > 0) || (wordq[i].size() > 0)));
         end
      end
   end

   // Send one word to an idle instance and check the frame against fixed bits.
   task automatic check_frame(input int i, input logic [7:0] d, input logic [15:0] bits, input int n);
      @(negedge sys_clk);
      s_valid[i] = 1'b1;
      s_data[i]  = d;
      @(posedge sys_clk);
      @(negedge sys_clk);
      s_valid[i] = 1'b0;
      check("f_acc_lvl", i, get_lvl(i), 32'd1);
      check("f_acc_txd", i, get_txd(i), 32'd1);
      @(posedge sys_clk);
      for (int j = 0; j < n * BPS_CNT; j++) begin
         @(negedge sys_clk);
         if ((j % BPS_CNT) == 0 || (j % BPS_CNT) == BPS_CNT - 1)
            check("f_bit", i, get_txd(i), 32'(bits[j / BPS_CNT]));
         if (j == n * BPS_CNT - 1) check("f_done_early", i, get_don(i), 32'd0);
      end
      @(negedge sys_clk);
      check("f_done", i, get_don(i), 32'd1);
      check("f_idle_txd", i, get_txd(i), 32'd1);
      @(negedge sys_clk);
      check("f_done_pulse", i, get_don(i), 32'd0);
   endtask

   task automatic wait_idle(input int i, input int max_cyc, output int dones);
      int c = 0;
      dones = 0;
      while (get_bsy(i) !== 32'd0 && c < max_cyc) begin
         @(negedge sys_clk);
         if (get_don(i) === 32'd1) dones++;
         c++;
      end
      check("idle_timeout", i, get_bsy(i), 32'd0);
   endtask

   initial begin
      int k, guard, dones, lows;
      for (int i = 0; i < 3; i++) s_data[i] = 8'h00;

      // reset values
      #1 sys_rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("rst_txd",   i, get_txd(i), 32'd1);
         check("rst_level", i, get_lvl(i), 32'd0);
         check("rst_ready", i, get_rdy(i), 32'd1);
         check("rst_busy",  i, get_bsy(i), 32'd0);
         check("rst_done",  i, get_don(i), 32'd0);
      end
      chk_en = 1'b1;
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);

      // 8N1 0x55, 7E2 0x03, 8O1 0x00 and 0xFF
      check_frame(0, 8'h55, 16'h02AA, 10);
      check_frame(1, 8'h03, 16'h0606, 11);
      check_frame(2, 8'h00, 16'h0600, 11);
      check_frame(2, 8'hFF, 16'h07FE, 11);

      // burst of five words into a depth-4 buffer
      @(negedge sys_clk);
      s_valid[0] = 1'b1;
      s_data[0]  = 8'h11;
      k = 0;
      guard = 0;
      while (k < 5 && guard < 50) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
         guard++;
         if (acc[0]) begin
            k++;
            if (k < 5) s_data[0] = 8'(8'h11 + k);
            else s_valid[0] = 1'b0;
         end
      end
      s_valid[0] = 1'b0;
      check("burst_accepted", 0, 32'(k), 32'd5);
      check("burst_cycles",   0, 32'(guard), 32'd5);
      check("burst_level",    0, get_lvl(0), 32'd4);
      check("burst_ready",    0, get_rdy(0), 32'd0);
      wait_idle(0, 800, dones);
      check("burst_frames", 0, 32'(dones), 32'd5);
      check("burst_level0", 0, get_lvl(0), 32'd0);

      // push on the same edge as the idle pop
      @(negedge sys_clk);
      s_valid[0] = 1'b1;
      s_data[0]  = 8'h3C;
      @(posedge sys_clk);
      @(negedge sys_clk);
      check("pp_level_pre", 0, get_lvl(0), 32'd1);
      s_data[0] = 8'hC3;
      @(posedge sys_clk);
      @(negedge sys_clk);
      s_valid[0] = 1'b0;
      check("pp_level", 0, get_lvl(0), 32'd1);
      check("pp_txd",   0, get_txd(0), 32'd0);
      wait_idle(0, 400, dones);
      check("pp_frames", 0, 32'(dones), 32'd2);

      // reset in the middle of DATA bit 3 of 0xA5
      @(negedge sys_clk);
      s_valid[0] = 1'b1;
      s_data[0]  = 8'hA5;
      @(posedge sys_clk);
      @(negedge sys_clk);
      s_valid[0] = 1'b0;
      @(posedge sys_clk);
      repeat (45) @(negedge sys_clk);
      check("mid_bit3", 0, get_txd(0), 32'd0);
      #2 sys_rst_n = 1'b0;
      #1;
      check("mid_rst_txd",   0, get_txd(0), 32'd1);
      check("mid_rst_level", 0, get_lvl(0), 32'd0);
      check("mid_rst_busy",  0, get_bsy(0), 32'd0);
      check("mid_rst_ready", 0, get_rdy(0), 32'd1);
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      lows = 0;
      repeat (50) begin
         @(negedge sys_clk);
         if (txd_a !== 1'b1) lows++;
      end
      check("post_rst_quiet", 0, 32'(lows), 32'd0);

      // random traffic on all three instances
      for (int c = 0; c < 3000; c++) begin
         @(negedge sys_clk);
         for (int i = 0; i < 3; i++) begin
            if (acc[i]) s_valid[i] = 1'b0;
            if (!s_valid[i]) begin
               s_data[i] = 8'($urandom);
               if ($urandom_range(0, 3) == 0) s_valid[i] = 1'b1;
            end
         end
      end
      @(negedge sys_clk);
      s_valid = '0;
      for (int i = 0; i < 3; i++) wait_idle(i, 1500, dones);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
